// File: rtl/reg_40xx_wr_queue_pkg.sv
// reg_40xx_wr_queue_pkg: shared register-file geometry for the write queue
package reg_40xx_wr_queue_pkg;
    localparam int RF_ENTRIES = 40;
    localparam int ADDR_W     = 6;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(RF_ENTRIES);
    endfunction
endpackage

// File: rtl/wr_queue_storage.sv
// wr_queue_storage: DEPTH x {addr,data} entry array with two write and two read ports,
// plus every stored address exposed for the read-hazard lookup
module wr_queue_storage
    import reg_40xx_wr_queue_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int EW    = ADDR_W + WIDTH
)(
    input  logic              clk,
    input  logic              i_we0,
    input  logic [PW-1:0]     i_wa0,
    input  logic [EW-1:0]     i_wd0,
    input  logic              i_we1,
    input  logic [PW-1:0]     i_wa1,
    input  logic [EW-1:0]     i_wd1,
    input  logic [PW-1:0]     i_ra0,
    input  logic [PW-1:0]     i_ra1,
    output logic [EW-1:0]     o_rd0,
    output logic [EW-1:0]     o_rd1,
    output logic [ADDR_W-1:0] o_addrs [DEPTH]
);
    logic [EW-1:0] r_mem [DEPTH];

    // the parent never writes both ports to the same slot
    always_ff @(posedge clk) begin
        if (i_we0) r_mem[i_wa0] <= i_wd0;
        if (i_we1) r_mem[i_wa1] <= i_wd1;
    end

    assign o_rd0 = r_mem[i_ra0];
    assign o_rd1 = r_mem[i_ra1];

    for (genvar g = 0; g < DEPTH; g++) begin : g_addr
        assign o_addrs[g] = r_mem[g][EW-1 -: ADDR_W];
    end
endmodule

// File: rtl/reg_40xx_wr_queue.sv
// reg_40xx_wr_queue: two-producer in-order write queue feeding a 40-entry 2-write register file,
// issuing up to two non-colliding entries per cycle with a read-hazard lookup
module reg_40xx_wr_queue
    import reg_40xx_wr_queue_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in0_valid,
    output logic                   in0_ready,
    input  logic [ADDR_W-1:0]      in0_addr,
    input  logic [WIDTH-1:0]       in0_data,
    input  logic                   in1_valid,
    output logic                   in1_ready,
    input  logic [ADDR_W-1:0]      in1_addr,
    input  logic [WIDTH-1:0]       in1_data,
    input  logic                   hold,
    output logic                   wr0_en,
    output logic [ADDR_W-1:0]      wr0_addr,
    output logic [WIDTH-1:0]       wr0_data,
    output logic                   wr1_en,
    output logic [ADDR_W-1:0]      wr1_addr,
    output logic [WIDTH-1:0]       wr1_data,
    input  logic [ADDR_W-1:0]      rd0_addr,
    input  logic [ADDR_W-1:0]      rd1_addr,
    output logic                   rd0_pending,
    output logic                   rd1_pending,
    output logic [$clog2(DEPTH):0] count,
    output logic                   addr_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + WIDTH;

    logic [PW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_addr_err;
    logic              w_push0, w_push1, w_pop0, w_pop1, w_head_bad, w_sec_bad;
    logic [PW-1:0]     w_wa1;
    logic [EW-1:0]     w_rd0, w_rd1;
    logic [ADDR_W-1:0] w_head_addr, w_sec_addr;
    logic [WIDTH-1:0]  w_head_data, w_sec_data;
    logic [ADDR_W-1:0] w_addrs [DEPTH];
    logic [DEPTH-1:0]  w_hit0, w_hit1;

    assign in0_ready = r_count <= CW'(DEPTH - 1);
    assign in1_ready = r_count <= CW'(DEPTH - 2);
    assign w_push0   = in0_valid & in0_ready;
    assign w_push1   = in1_valid & in1_ready;
    assign w_wa1     = w_push0 ? r_wptr + PW'(1) : r_wptr;

    wr_queue_storage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_storage (
        .clk     (clk),
        .i_we0   (w_push0),
        .i_wa0   (r_wptr),
        .i_wd0   ({in0_addr, in0_data}),
        .i_we1   (w_push1),
        .i_wa1   (w_wa1),
        .i_wd1   ({in1_addr, in1_data}),
        .i_ra0   (r_rptr),
        .i_ra1   (r_rptr + PW'(1)),
        .o_rd0   (w_rd0),
        .o_rd1   (w_rd1),
        .o_addrs (w_addrs)
    );

    assign {w_head_addr, w_head_data} = w_rd0;
    assign {w_sec_addr, w_sec_data}   = w_rd1;
    assign w_head_bad = !addr_ok(w_head_addr);
    assign w_sec_bad  = !addr_ok(w_sec_addr);

    // out-of-range entries pop exactly as if issued; only the enables are suppressed
    assign w_pop0 = (r_count != '0) & ~hold;
    assign w_pop1 = w_pop0 & (r_count >= CW'(2)) & (w_sec_addr != w_head_addr);
    assign wr0_en   = w_pop0 & ~w_head_bad;
    assign wr1_en   = w_pop1 & ~w_sec_bad;
    assign wr0_addr = w_head_addr;
    assign wr0_data = w_head_data;
    assign wr1_addr = w_sec_addr;
    assign wr1_data = w_sec_data;

    for (genvar g = 0; g < DEPTH; g++) begin : g_hit
        logic [PW-1:0] w_off;
        logic          w_live;
        assign w_off     = PW'(g) - r_rptr;
        assign w_live    = {1'b0, w_off} < r_count;
        assign w_hit0[g] = w_live & (w_addrs[g] == rd0_addr);
        assign w_hit1[g] = w_live & (w_addrs[g] == rd1_addr);
    end

    assign rd0_pending = |w_hit0;
    assign rd1_pending = |w_hit1;
    assign count       = r_count;
    assign addr_err    = r_addr_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_push0) + PW'(w_push1);
            r_rptr  <= r_rptr + PW'(w_pop0) + PW'(w_pop1);
            r_count <= r_count + CW'(w_push0) + CW'(w_push1) - CW'(w_pop0) - CW'(w_pop1);
            if ((w_pop0 & w_head_bad) | (w_pop1 & w_sec_bad)) r_addr_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_40xx_wr_queue.sv
// tb_reg_40xx_wr_queue: directed stimulus with a scoreboard of expected register-file writes
module tb_reg_40xx_wr_queue;
    logic        clk, rst, hold;
    logic        in0_valid, in0_ready, in1_valid, in1_ready;
    logic [5:0]  in0_addr, in1_addr;
    logic [63:0] in0_data, in1_data;
    logic        wr0_en, wr1_en;
    logic [5:0]  wr0_addr, wr1_addr;
    logic [63:0] wr0_data, wr1_data;
    logic [5:0]  rd0_addr, rd1_addr;
    logic        rd0_pending, rd1_pending;
    logic [3:0]  count;
    logic        addr_err;

    int          checks = 0;
    int          failures = 0;
    logic [69:0] sbq [$];
    logic [63:0] rf [64];

    reg_40xx_wr_queue #(.WIDTH(64), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_addr(in0_addr), .in0_data(in0_data),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_addr(in1_addr), .in1_data(in1_data),
        .hold(hold),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
        .rd0_pending(rd0_pending), .rd1_pending(rd1_pending),
        .count(count), .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mon(input string nm, input logic [5:0] a, input logic [63:0] d);
        logic [69:0] e;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected: got write addr %0d data %0h expected none", nm, a, d);
        end else begin
            e = sbq.pop_front();
            chk({nm, "_addr"}, 64'(a), 64'(e[69:64]));
            chk({nm, "_data"}, d, e[63:0]);
        end
        rf[a] = d;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (wr0_en) mon("wr0", wr0_addr, wr0_data);
            if (wr1_en) mon("wr1", wr1_addr, wr1_data);
            if (wr0_en && wr1_en) chk("wr_addr_distinct", 64'(wr0_addr == wr1_addr), 64'(0));
        end
    end

    // e0/e1: whether each offered entry is expected to be accepted and later written
    task automatic cyc(input logic v0, input logic [5:0] a0, input logic [63:0] d0,
                       input logic v1, input logic [5:0] a1, input logic [63:0] d1,
                       input logic e0, input logic e1);
        in0_valid = v0; in0_addr = a0; in0_data = d0;
        in1_valid = v1; in1_addr = a1; in1_data = d1;
        if (e0 && a0 < 40) sbq.push_back({a0, d0});
        if (e1 && a1 < 40) sbq.push_back({a1, d1});
        @(posedge clk); #1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; hold = 1'b0;
        in0_valid = 1'b0; in0_addr = '0; in0_data = '0;
        in1_valid = 1'b0; in1_addr = '0; in1_data = '0;
        rd0_addr = 6'd5; rd1_addr = 6'd0;
        for (int i = 0; i < 64; i++) rf[i] = '0;
        #12;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_in0_ready", 64'(in0_ready), 64'(1));
        chk("rst_in1_ready", 64'(in1_ready), 64'(1));
        chk("rst_wr0_en", 64'(wr0_en), 64'(0));
        chk("rst_addr_err", 64'(addr_err), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;

        cyc(1, 6'd5, 64'hA5, 0, 6'd0, 64'h0, 1, 0);
        chk("single_count1", 64'(count), 64'(1));
        chk("single_wr0_en", 64'(wr0_en), 64'(1));
        chk("single_wr1_en", 64'(wr1_en), 64'(0));
        chk("single_pending", 64'(rd0_pending), 64'(1));
        idle();
        chk("single_count0", 64'(count), 64'(0));
        chk("single_pending0", 64'(rd0_pending), 64'(0));

        cyc(1, 6'd3, 64'h33, 1, 6'd7, 64'h77, 1, 1);
        chk("dual_wr0_en", 64'(wr0_en), 64'(1));
        chk("dual_wr1_en", 64'(wr1_en), 64'(1));
        idle();
        chk("dual_count0", 64'(count), 64'(0));

        cyc(1, 6'd9, 64'h1, 1, 6'd9, 64'h2, 1, 1);
        chk("coll_count2", 64'(count), 64'(2));
        chk("coll_wr0_en", 64'(wr0_en), 64'(1));
        chk("coll_wr1_en", 64'(wr1_en), 64'(0));
        idle();
        chk("coll_count1", 64'(count), 64'(1));
        chk("coll_second_wr0_en", 64'(wr0_en), 64'(1));
        idle();
        chk("coll_count0", 64'(count), 64'(0));
        chk("coll_rf9", rf[9], 64'h2);

        hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 6'(10 + i), 64'(256 + i), 0, 6'd0, 64'h0, 1, 0);
            chk("full_count", 64'(count), 64'(i + 1));
            chk("full_in0_ready", 64'(in0_ready), 64'(i + 1 < 8));
            chk("full_in1_ready", 64'(in1_ready), 64'(i + 1 < 7));
        end
        chk("full_hold_wr0_en", 64'(wr0_en), 64'(0));
        cyc(1, 6'd30, 64'h30, 0, 6'd0, 64'h0, 0, 0);
        chk("full_no_overflow", 64'(count), 64'(8));
        hold = 1'b0;
        for (int j = 0; j < 4; j++) begin
            idle();
            chk("drain_count", 64'(count), 64'(6 - 2 * j));
        end

        cyc(1, 6'd45, 64'hBAD, 1, 6'd39, 64'h39, 1, 1);
        chk("bad_count2", 64'(count), 64'(2));
        chk("bad_wr0_en", 64'(wr0_en), 64'(0));
        chk("bad_wr1_en", 64'(wr1_en), 64'(1));
        chk("bad_err_before", 64'(addr_err), 64'(0));
        idle();
        chk("bad_popped", 64'(count), 64'(0));
        chk("bad_err_set", 64'(addr_err), 64'(1));
        cyc(1, 6'd40, 64'h40, 0, 6'd0, 64'h0, 1, 0);
        chk("bad40_wr0_en", 64'(wr0_en), 64'(0));
        idle();
        chk("bad40_popped", 64'(count), 64'(0));
        idle(); idle();
        chk("bad_err_sticky", 64'(addr_err), 64'(1));

        hold = 1'b1;
        cyc(1, 6'd21, 64'h21, 1, 6'd22, 64'h22, 0, 0);
        cyc(1, 6'd23, 64'h23, 1, 6'd24, 64'h24, 0, 0);
        cyc(1, 6'd25, 64'h25, 0, 6'd0, 64'h0, 0, 0);
        chk("mid_count5", 64'(count), 64'(5));
        chk("mid_in1_ready", 64'(in1_ready), 64'(1));
        rd1_addr = 6'd23;
        #1;
        chk("mid_pending", 64'(rd1_pending), 64'(1));
        rst = 1'b0;
        hold = 1'b0;
        #1;
        chk("mid_rst_count", 64'(count), 64'(0));
        chk("mid_rst_wr0_en", 64'(wr0_en), 64'(0));
        chk("mid_rst_wr1_en", 64'(wr1_en), 64'(0));
        chk("mid_rst_pending", 64'(rd1_pending), 64'(0));
        chk("mid_rst_in0_ready", 64'(in0_ready), 64'(1));
        chk("mid_rst_in1_ready", 64'(in1_ready), 64'(1));
        chk("mid_rst_addr_err", 64'(addr_err), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        cyc(1, 6'd1, 64'h11, 0, 6'd0, 64'h0, 1, 0);
        chk("post_rst_count", 64'(count), 64'(1));
        chk("post_rst_wr0_en", 64'(wr0_en), 64'(1));
        idle(); idle();
        chk("post_rst_count0", 64'(count), 64'(0));
        chk("sb_empty", 64'(sbq.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_40xx_wr_queue.md
REG_40XX_WR_QUEUE -- requirements
Module: reg_40xX_wr_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 64, giving the data width of every write word.
REQ-002 SHALL have parameter DEPTH, default 8 (power of two, at least 4), giving the number of queue entries.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports in0_valid/in0_ready (1 bit in/out), in0_addr (6 bits in) and in0_data (WIDTH bits in): producer port 0.
REQ-006 SHALL have ports in1_valid/in1_ready (1 bit in/out), in1_addr (6 bits in) and in1_data (WIDTH bits in): producer port 1; same cycle, in1 is younger than in0.
REQ-007 SHALL have input hold, 1 bit: while high, no entry is issued.
REQ-008 SHALL have outputs wr0_en, wr0_addr[5:0] and wr0_data[WIDTH-1:0]: write port 0 to the 40-entry 2-write register file.
REQ-009 SHALL have outputs wr1_en, wr1_addr[5:0] and wr1_data[WIDTH-1:0]: write port 1 to the same register file.
REQ-010 SHALL have inputs rd0_addr[5:0] and rd1_addr[5:0], and outputs rd0_pending and rd1_pending (1 bit each): the read-hazard lookup.
REQ-011 SHALL have output count[$clog2(DEPTH):0] (occupancy) and output addr_err (1 bit, sticky).

Function
REQ-012 SHALL be an in-order FIFO of {addr, data} entries; entry order is by cycle, then in0 before in1.
REQ-013 SHALL drive in0_ready = (DEPTH - count >= 1) and in1_ready = (DEPTH - count >= 2); neither depends on valid or on same-cycle issue.
REQ-014 SHALL enqueue each port whose valid and ready are both high at the edge; in1 alone occupies the next free slot.
REQ-015 SHALL present the head entry on wr0_* and the next entry on wr1_* combinationally from registered queue state; an entry enqueued at edge N is visible on the ports no earlier than cycle N+1.
REQ-016 SHALL assert wr0_en when the queue is non-empty, hold is low and the head address is < 40.
REQ-017 SHALL assert wr1_en when count >= 2, hold is low, wr0 issues, the second address is < 40 and the second address differs from the head address.
REQ-018 SHALL, on a head/second address collision, issue only the head in that cycle; the second entry becomes the head next cycle, so the younger data lands last.
REQ-019 SHALL never drive equal addresses with both wr0_en and wr1_en high in the same cycle.
REQ-020 SHALL pop an entry whose address is >= 40 without issuing it, set addr_err, and apply the REQ-016/017 pop rules to it as if it had issued.
REQ-021 SHALL pop 0, 1 or 2 entries per cycle, and SHALL set count_next = count + pushes - pops.
REQ-022 SHALL drive rdN_pending high when any valid queue entry holds address rdN_addr; in-flight producer inputs are excluded.
REQ-023 SHALL wrap read and write pointers modulo DEPTH.

Reset
REQ-024 SHALL, on rst low, immediately clear pointers, count and addr_err, forcing wr0_en, wr1_en, rd0_pending and rd1_pending low and both readies high.
REQ-025 SHALL discard queue contents on reset mid-operation; entry storage itself is not reset.
REQ-026 SHALL deassert reset synchronously in effect: the first enqueue is accepted at the first rising edge with rst high.

Structure
REQ-027 SHALL take the register-file entry count (40) and the address width (6) from constants in the shared global definitions include.
REQ-028 SHALL implement entry storage as one sub-module, wr_queue_storage: DEPTH x (6+WIDTH) storage with 2 write ports and 2 read ports, with push/pop logic in the parent.

Verification
REQ-029 SHALL cover single write: in0 addr 5, data 0xA5 -> wr0_en high next cycle with addr 5, data 0xA5, wr1_en low, and count 1 then 0.
REQ-030 SHALL cover dual issue: in0 addr 3, in1 addr 7 in the same cycle -> next cycle wr0 = 3 and wr1 = 7 both enabled, and count returns to 0.
REQ-031 SHALL cover a collision: in0 addr 9 data 1 and in1 addr 9 data 2 -> wr0 issues data 1 alone, then data 2 next cycle, and entry 9 finally holds 2.
REQ-032 SHALL cover full: hold high while enqueuing 8 entries -> in1_ready drops at count 7 and in0_ready drops at count 8, no overflow occurs, and release of hold drains in 4 cycles.
REQ-033 SHALL cover a bad address: enqueue addr 45 -> wr0_en never asserted for it, it is popped, and addr_err stays 1 until reset.
REQ-034 SHALL cover reset mid-operation: with 5 entries queued, rst is pulsed low -> count 0, wr*_en low, pending low and both readies high immediately.
